// File: rtl/four_bit_xor_checksum.sv
// four_bit_xor_checksum
// Frame-level checksum accumulator fed by the four_bit_xor2 nibble stream.
// XOR-folds a frame of nibbles into one 4-bit checksum. It reports the frame
// length, the checksum parity and a length-error flag. The result is held
// until the consumer accepts it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   x          input nibble
//   in_valid   x / in_last valid this cycle
//   in_last    current nibble closes the frame
//   in_ready   block accepts a nibble this cycle
//   sum        XOR of all nibbles of the frame (0 unless sum_valid)
//   len        number of nibbles in the frame (0 unless sum_valid)
//   parity     ^sum (0 unless sum_valid)
//   len_err    frame force-closed at MAX_NIBBLES (0 unless sum_valid)
//   sum_valid  result outputs valid
//   out_ready  consumer accepts the result this cycle
module four_bit_xor_checksum #(
   parameter int MAX_NIBBLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] x,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [3:0] sum,
   output logic [3:0] len,
   output logic       parity,
   output logic       len_err,
   output logic       sum_valid,
   input  logic       out_ready
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_NIBBLES);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t     state, state_nxt;
   logic [3:0] acc, acc_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       err, err_nxt;
   logic       accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         err   <= err_nxt;
      end
   end

   // Handshake outputs are decoded from the state register only. This keeps
   // in_valid and x off every combinational path to an output.
   always_comb begin
      in_ready  = (state != HOLD);
      sum_valid = (state == HOLD);
      accept    = in_valid & in_ready;
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      err_nxt   = err;
      unique case (state)
         IDLE: begin
            if (accept) begin
               acc_nxt = x;
               cnt_nxt = 4'd1;
               err_nxt = 1'b0;
               state_nxt = (in_last || MAX_CNT == 4'd1) ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               acc_nxt = acc ^ x;
               cnt_nxt = cnt + 4'd1;
               if (in_last) begin
                  state_nxt = HOLD;
                  err_nxt   = 1'b0;
               end else if (cnt + 4'd1 == MAX_CNT) begin
                  // Frame hit its length limit without in_last: close it and flag it.
                  state_nxt = HOLD;
                  err_nxt   = 1'b1;
               end
            end
         end
         HOLD: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Result outputs read as zero outside HOLD.
   always_comb begin
      sum     = sum_valid ? acc : 4'd0;
      len     = sum_valid ? cnt : 4'd0;
      len_err = sum_valid & err;
      parity  = sum_valid & (^acc);
   end

endmodule

// File: tb/tb_four_bit_xor_checksum.sv
module tb_four_bit_xor_checksum;
   localparam int MAXN = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] x = '0;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b1;
   logic       in_ready, parity, len_err, sum_valid;
   logic [3:0] sum, len;

   int checks = 0;
   int errors = 0;

   four_bit_xor_checksum #(.MAX_NIBBLES(MAXN)) dut (
      .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .sum(sum), .len(len), .parity(parity),
      .len_err(len_err), .sum_valid(sum_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: list of nibbles in the open frame plus one pending result.
   int         frame_q[$];
   bit         pend = 0;
   bit         chk_en = 0;
   logic [3:0] e_sum = '0, e_len = '0;
   bit         e_err = 0;

   always @(posedge clk) begin
      if (rst) begin
         frame_q.delete();
         pend = 0;
         chk_en = 1;
      end else if (chk_en) begin
         if (pend) begin
            if (out_ready) pend = 0;
         end else if (in_valid) begin
            frame_q.push_back(int'(x));
            if (in_last || frame_q.size() == MAXN) begin
               e_sum = 4'd0;
               foreach (frame_q[i]) e_sum = e_sum ^ 4'(frame_q[i]);
               e_len = 4'(frame_q.size());
               e_err = !in_last;
               pend  = 1;
               frame_q.delete();
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", {7'd0, in_ready}, {7'd0, !pend});
         chk("sum_valid", {7'd0, sum_valid}, {7'd0, pend});
         chk("sum", {4'd0, sum}, {4'd0, pend ? e_sum : 4'd0});
         chk("len", {4'd0, len}, {4'd0, pend ? e_len : 4'd0});
         chk("parity", {7'd0, parity}, {7'd0, pend ? ^e_sum : 1'b0});
         chk("len_err", {7'd0, len_err}, {7'd0, pend ? e_err : 1'b0});
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Presents one nibble and holds it until accepted, then drops in_valid.
   task automatic send(input logic [3:0] v, input logic last);
      bit ok;
      int n;
      x = v; in_last = last; in_valid = 1'b1;
      n = 0;
      do begin
         ok = in_ready;
         step();
         n++;
      end while (!ok && n < 20);
      if (!ok) chk("send_timeout", 8'd0, 8'd1);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic res(input string name, input logic [3:0] s, input logic [3:0] l,
                      input logic p, input logic e);
      chk({name, "_valid"}, {7'd0, sum_valid}, 8'd1);
      chk({name, "_sum"}, {4'd0, sum}, {4'd0, s});
      chk({name, "_len"}, {4'd0, len}, {4'd0, l});
      chk({name, "_par"}, {7'd0, parity}, {7'd0, p});
      chk({name, "_err"}, {7'd0, len_err}, {7'd0, e});
      chk({name, "_model_sum"}, {4'd0, e_sum}, {4'd0, s});
      chk({name, "_model_len"}, {4'd0, e_len}, {4'd0, l});
   endtask

   initial begin
      step(); step();
      rst = 1'b0;
      chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
      chk("rst_sum_valid", {7'd0, sum_valid}, 8'd0);
      chk("rst_sum", {4'd0, sum}, 8'd0);

      // basic frame
      send(4'h6, 0); send(4'hA, 0); send(4'h3, 1);
      res("basic", 4'hF, 4'd3, 1'b0, 1'b0);
      step();
      chk("basic_drop", {7'd0, sum_valid}, 8'd0);

      // single nibble frame
      send(4'h9, 1);
      res("single", 4'h9, 4'd1, 1'b0, 1'b0);
      step();

      // upstream chaining: x = a ^ b
      send(4'h3 ^ 4'h5, 0); send(4'hC ^ 4'h0, 1);
      res("chain", 4'hA, 4'd2, 1'b0, 1'b0);
      step();

      // gaps inside a frame
      send(4'h1, 0); step(); step();
      send(4'h2, 1);
      res("gap", 4'h3, 4'd2, 1'b0, 1'b0);
      step();

      // backpressure with a nibble waiting upstream
      out_ready = 1'b0;
      send(4'h5, 1);
      x = 4'h7; in_last = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         res("bp_hold", 4'h5, 4'd1, 1'b0, 1'b0);
         chk("bp_in_ready", {7'd0, in_ready}, 8'd0);
         step();
      end
      out_ready = 1'b1;
      res("bp_hold6", 4'h5, 4'd1, 1'b0, 1'b0);
      step();
      chk("bp_idle_ready", {7'd0, in_ready}, 8'd1);
      chk("bp_idle_valid", {7'd0, sum_valid}, 8'd0);
      step();
      in_valid = 1'b0; in_last = 1'b0;
      res("bp_next", 4'h7, 4'd1, 1'b1, 1'b0);
      step();

      // length overflow
      for (int i = 0; i < MAXN; i++) send(4'h1, 0);
      res("ovf", 4'h0, 4'd8, 1'b0, 1'b1);
      step();

      // reset mid-frame
      send(4'h7, 0); send(4'h2, 0);
      rst = 1'b1; step(); rst = 1'b0;
      chk("mrst_in_ready", {7'd0, in_ready}, 8'd1);
      chk("mrst_valid", {7'd0, sum_valid}, 8'd0);
      chk("mrst_sum", {4'd0, sum}, 8'd0);
      send(4'h4, 1);
      res("mrst", 4'h4, 4'd1, 1'b1, 1'b0);
      step();

      // reset while a result is held
      out_ready = 1'b0;
      send(4'hB, 1);
      res("hrst_pre", 4'hB, 4'd1, 1'b1, 1'b0);
      rst = 1'b1; step(); rst = 1'b0;
      out_ready = 1'b1;
      chk("hrst_valid", {7'd0, sum_valid}, 8'd0);
      chk("hrst_len", {4'd0, len}, 8'd0);
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
